// File: rtl/writeback_unit.sv
// ============================================================================
//  Module   : writeback_unit
//  Purpose  : RV32I writeback stage. Selects the result source, waits for the
//             load response, formats load data and drives the register-file
//             write port.
//  Options  : WB_MISALIGN_TRAP_EN - trap misaligned LH/LHU/LW at acceptance
//             instead of force-aligning them.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module writeback_unit (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        wb_valid_in,
    input  logic [4:0]  rd_addr_wb_in,
    input  logic [1:0]  wb_sel_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] pc_plus4_in,
    input  logic [31:0] csr_data_in,
    input  logic        dmem_rvalid_in,
    input  logic [31:0] dmem_rdata_in,
    output logic [4:0]  rd_addr_out,
    output logic [31:0] rd_out,
    output logic        wr_en_out,
    output logic        stall_out
`ifdef WB_MISALIGN_TRAP_EN
    ,
    output logic        misaligned_out
`endif
);

    localparam logic [1:0] c_SEL_ALU  = 2'b00;
    localparam logic [1:0] c_SEL_LOAD = 2'b01;
    localparam logic [1:0] c_SEL_PC4  = 2'b10;

    typedef enum logic [0:0] {
        S_IDLE     = 1'b0,
        S_WAIT_MEM = 1'b1
    } state_t;

    state_t      r_state;
    logic [4:0]  r_rd_addr;
    logic [31:0] r_rd;
    logic        r_wr_en;
    logic [4:0]  r_ld_rd;
    logic [2:0]  r_ld_funct3;
    logic [1:0]  r_ld_off;

    logic [31:0] w_sel_data;
    logic [31:0] w_load_data;
    logic        w_misaligned;

    // Halfword lane uses offset[1] only and LW ignores the offset, so a
    // misaligned access is silently force-aligned when it reaches this point.
    function automatic logic [31:0] fmt_load(
        input logic [2:0]  f3,
        input logic [1:0]  off,
        input logic [31:0] word
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b100:  res = {24'd0, b};
            3'b101:  res = {16'd0, h};
            default: res = word;
        endcase
        return res;
    endfunction

    always_comb begin
        w_sel_data = csr_data_in;
        if (wb_sel_in == c_SEL_ALU) begin
            w_sel_data = alu_result_in;
        end else if (wb_sel_in == c_SEL_PC4) begin
            w_sel_data = pc_plus4_in;
        end
    end

    assign w_load_data = fmt_load(r_ld_funct3, r_ld_off, dmem_rdata_in);

`ifdef WB_MISALIGN_TRAP_EN
    logic r_misaligned;

    // Byte loads can never be misaligned; reserved encodings behave as LW.
    always_comb begin
        case (funct3_in)
            3'b000, 3'b100: w_misaligned = 1'b0;
            3'b001, 3'b101: w_misaligned = alu_result_in[0];
            default:        w_misaligned = |alu_result_in[1:0];
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= (r_state == S_IDLE) && wb_valid_in &&
                            (wb_sel_in == c_SEL_LOAD) && w_misaligned;
        end
    end

    assign misaligned_out = r_misaligned;
`else
    assign w_misaligned = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= S_IDLE;
            r_rd_addr   <= 5'd0;
            r_rd        <= 32'd0;
            r_wr_en     <= 1'b0;
            r_ld_rd     <= 5'd0;
            r_ld_funct3 <= 3'd0;
            r_ld_off    <= 2'd0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (wb_valid_in) begin
                        if (wb_sel_in != c_SEL_LOAD) begin
                            r_rd      <= w_sel_data;
                            r_rd_addr <= rd_addr_wb_in;
                            r_wr_en   <= (rd_addr_wb_in != 5'd0);
                        end else if (!w_misaligned) begin
                            r_ld_rd     <= rd_addr_wb_in;
                            r_ld_funct3 <= funct3_in;
                            r_ld_off    <= alu_result_in[1:0];
                            r_state     <= S_WAIT_MEM;
                        end
                    end
                end
                S_WAIT_MEM: begin
                    if (dmem_rvalid_in) begin
                        r_rd      <= w_load_data;
                        r_rd_addr <= r_ld_rd;
                        r_wr_en   <= (r_ld_rd != 5'd0);
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rd_addr_out = r_rd_addr;
    assign rd_out      = r_rd;
    assign wr_en_out   = r_wr_en;
    assign stall_out   = (r_state == S_WAIT_MEM);

endmodule

`default_nettype wire

// File: tb/tb_writeback_unit.sv
// ============================================================================
//  Module   : tb_writeback_unit
//  Purpose  : Scoreboard bench for writeback_unit; expected register-file
//             writes are queued at issue and checked by an independent monitor.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_writeback_unit;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        wb_valid_in;
    logic [4:0]  rd_addr_wb_in;
    logic [1:0]  wb_sel_in;
    logic [2:0]  funct3_in;
    logic [31:0] alu_result_in;
    logic [31:0] pc_plus4_in;
    logic [31:0] csr_data_in;
    logic        dmem_rvalid_in;
    logic [31:0] dmem_rdata_in;
    logic [4:0]  rd_addr_out;
    logic [31:0] rd_out;
    logic        wr_en_out;
    logic        stall_out;
`ifdef WB_MISALIGN_TRAP_EN
    logic        misaligned_out;
`endif

    writeback_unit dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .wb_valid_in    (wb_valid_in),
        .rd_addr_wb_in  (rd_addr_wb_in),
        .wb_sel_in      (wb_sel_in),
        .funct3_in      (funct3_in),
        .alu_result_in  (alu_result_in),
        .pc_plus4_in    (pc_plus4_in),
        .csr_data_in    (csr_data_in),
        .dmem_rvalid_in (dmem_rvalid_in),
        .dmem_rdata_in  (dmem_rdata_in),
        .rd_addr_out    (rd_addr_out),
        .rd_out         (rd_out),
        .wr_en_out      (wr_en_out),
        .stall_out      (stall_out)
`ifdef WB_MISALIGN_TRAP_EN
        ,
        .misaligned_out (misaligned_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t q_exp[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Monitor: every write pulse must match the oldest outstanding expectation.
    always @(negedge clk_in) begin
        if (wr_en_out === 1'b1) begin
            if (q_exp.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got rd%0d=%08h expected no write", rd_addr_out, rd_out);
            end else begin
                wr_t e;
                e = q_exp.pop_front();
                chk("wr_addr", {27'd0, rd_addr_out}, {27'd0, e.addr});
                chk("wr_data", rd_out, e.data);
            end
        end
    end

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        q_exp.push_back(e);
    endtask

    task automatic set_instr(input logic [1:0] sel, input logic [4:0] rd, input logic [2:0] f3,
                             input logic [31:0] val);
        wb_valid_in   = 1'b1;
        wb_sel_in     = sel;
        rd_addr_wb_in = rd;
        funct3_in     = f3;
        alu_result_in = (sel == 2'b00 || sel == 2'b01) ? val : 32'h5555_0000;
        pc_plus4_in   = (sel == 2'b10) ? val : 32'h6666_0000;
        csr_data_in   = (sel == 2'b11) ? val : 32'h7777_0000;
        if (sel != 2'b01 && rd != 5'd0) expect_wr(rd, val);
    endtask

    task automatic issue(input logic [1:0] sel, input logic [4:0] rd, input logic [31:0] val);
        set_instr(sel, rd, 3'b000, val);
        @(posedge clk_in); #1;
        wb_valid_in = 1'b0;
    endtask

    // Load accepted at edge N; rvalid driven so that stall lasts n_stall cycles.
    task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input int n_stall, input logic [31:0] exp);
        set_instr(2'b01, rd, f3, addr);
        @(posedge clk_in); #1;
        wb_valid_in = 1'b0;
        for (int i = 0; i < n_stall; i++) begin
            if (i == n_stall - 1) begin
                dmem_rvalid_in = 1'b1;
                dmem_rdata_in  = rdata;
                if (rd != 5'd0) expect_wr(rd, exp);
            end
            @(negedge clk_in);
            chk("stall_during_load", {31'd0, stall_out}, 32'd1);
            @(posedge clk_in); #1;
        end
        dmem_rvalid_in = 1'b0;
        dmem_rdata_in  = 32'hDEAD_0000;
        @(negedge clk_in);
        chk("stall_after_load", {31'd0, stall_out}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in         = 1'b1;
        wb_valid_in    = 1'b0;
        rd_addr_wb_in  = 5'd0;
        wb_sel_in      = 2'b00;
        funct3_in      = 3'b000;
        alu_result_in  = 32'd0;
        pc_plus4_in    = 32'd0;
        csr_data_in    = 32'd0;
        dmem_rvalid_in = 1'b0;
        dmem_rdata_in  = 32'd0;
        repeat (3) @(posedge clk_in);
        #1;
        @(negedge clk_in);
        chk("rst_wr_en", {31'd0, wr_en_out}, 32'd0);
        chk("rst_rd_out", rd_out, 32'd0);
        chk("rst_rd_addr", {27'd0, rd_addr_out}, 32'd0);
        chk("rst_stall", {31'd0, stall_out}, 32'd0);
`ifdef WB_MISALIGN_TRAP_EN
        chk("rst_misaligned", {31'd0, misaligned_out}, 32'd0);
`endif
        @(posedge clk_in); #1;
        rst_in = 1'b0;

        // Non-load sources, including x0 suppression
        issue(2'b00, 5'd5, 32'h0000_1234);
        @(posedge clk_in); #1;
        issue(2'b10, 5'd0, 32'h0000_0104);
        @(negedge clk_in);
        chk("x0_rd_out", rd_out, 32'h0000_0104);
        chk("x0_wr_en", {31'd0, wr_en_out}, 32'd0);
        issue(2'b10, 5'd1, 32'h0000_0104);
        issue(2'b11, 5'd31, 32'hDEAD_BEEF);

        // Back-to-back non-loads
        set_instr(2'b00, 5'd10, 3'b000, 32'h0000_000A);
        @(posedge clk_in); #1;
        set_instr(2'b00, 5'd11, 3'b000, 32'h0000_000B);
        @(posedge clk_in); #1;
        wb_valid_in = 1'b0;

        // Stray rvalid while idle must be ignored
        dmem_rvalid_in = 1'b1;
        dmem_rdata_in  = 32'h1111_1111;
        @(posedge clk_in); #1;
        dmem_rvalid_in = 1'b0;
        @(negedge clk_in);
        chk("stray_rvalid_stall", {31'd0, stall_out}, 32'd0);

        // Loads: formatting and latency
        do_load(5'd7,  3'b000, 32'h0000_1003, 32'h80FF_7F01, 2, 32'hFFFF_FF80);
        do_load(5'd7,  3'b100, 32'h0000_1003, 32'h80FF_7F01, 1, 32'h0000_0080);
        issue(2'b00, 5'd12, 32'h0000_0C0C);
        do_load(5'd8,  3'b000, 32'h0000_1001, 32'h80FF_7F01, 3, 32'h0000_007F);
        do_load(5'd8,  3'b101, 32'h0000_2002, 32'hBEEF_0000, 1, 32'h0000_BEEF);
        do_load(5'd8,  3'b001, 32'h0000_2002, 32'hBEEF_0000, 2, 32'hFFFF_BEEF);
        do_load(5'd3,  3'b101, 32'h0000_2000, 32'h1234_7FFF, 1, 32'h0000_7FFF);
        do_load(5'd9,  3'b010, 32'h0000_3000, 32'hCAFE_F00D, 1, 32'hCAFE_F00D);
        do_load(5'd9,  3'b011, 32'h0000_3000, 32'h0BAD_CAFE, 1, 32'h0BAD_CAFE);
        do_load(5'd0,  3'b010, 32'h0000_3000, 32'h1357_9BDF, 2, 32'h0);
        issue(2'b00, 5'd13, 32'h0000_0D0D);

        // Reset in WAIT_MEM coincident with rvalid: no write
        set_instr(2'b01, 5'd14, 3'b010, 32'h0000_4000);
        @(posedge clk_in); #1;
        wb_valid_in = 1'b0;
        @(negedge clk_in);
        chk("pre_rst_stall", {31'd0, stall_out}, 32'd1);
        rst_in         = 1'b1;
        dmem_rvalid_in = 1'b1;
        dmem_rdata_in  = 32'h9999_9999;
        @(posedge clk_in); #1;
        rst_in         = 1'b0;
        dmem_rvalid_in = 1'b0;
        @(negedge clk_in);
        chk("rst_mid_load_stall", {31'd0, stall_out}, 32'd0);
        chk("rst_mid_load_wr_en", {31'd0, wr_en_out}, 32'd0);
        @(posedge clk_in); #1;

        // Misaligned LW at offset 2
`ifdef WB_MISALIGN_TRAP_EN
        set_instr(2'b01, 5'd15, 3'b010, 32'h0000_5002);
        @(posedge clk_in); #1;
        wb_valid_in = 1'b0;
        @(negedge clk_in);
        chk("misaligned_pulse", {31'd0, misaligned_out}, 32'd1);
        chk("misaligned_stall", {31'd0, stall_out}, 32'd0);
        chk("misaligned_rd_out", rd_out, 32'd0);
        @(posedge clk_in); #1;
        @(negedge clk_in);
        chk("misaligned_clear", {31'd0, misaligned_out}, 32'd0);
`else
        do_load(5'd15, 3'b010, 32'h0000_5002, 32'h1122_3344, 1, 32'h1122_3344);
`endif

        repeat (4) @(posedge clk_in);
        #1;
        chk("pending_writes", q_exp.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
